// File: rtl/bus_interface_unit_if.sv
// rtl/bus_interface_unit_if.sv - core-side request/response bundle for the bus interface unit
interface bus_interface_unit_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
);
    logic                  req;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr_in;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  ack;
    logic                  timeout;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  busy;

    // Core issues requests and consumes completions.
    modport master (
        output req, we, addr_in, wdata,
        input  ack, timeout, rdata, busy
    );

    // Bus interface unit accepts requests and reports completions.
    modport slave (
        input  req, we, addr_in, wdata,
        output ack, timeout, rdata, busy
    );
endinterface

// File: rtl/bus_interface_unit.sv
// rtl/bus_interface_unit.sv - single-outstanding external memory access sequencer (AB/DOR/DL)
module bus_interface_unit #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_WAIT   = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    bus_interface_unit_if.slave   core,
    output logic [ADDR_WIDTH-1:0] ab,
    output logic                  rw,
    output logic [DATA_WIDTH-1:0] db_out,
    output logic                  db_oe,
    input  logic [DATA_WIDTH-1:0] db_in,
    input  logic                  mem_rdy
);

    localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);
    localparam bit         WAIT_EN    = (MAX_WAIT != 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [7:0]            wait_cnt;
    logic                  ack_q;
    logic                  timeout_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic                  start;
    logic                  done_ok;
    logic                  expired;
    logic                  busy;

    // State register; reset aborts any access in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: IDLE -> ADDR -> DATA, leaving DATA on ready or wait expiry.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (core.req) state_nxt = ADDR;
            ADDR:    state_nxt = DATA;
            DATA:    if (done_ok || expired) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Decode of the registered state; ready beats expiry on the same edge.
    always_comb begin
        start   = 1'b0;
        done_ok = 1'b0;
        expired = 1'b0;
        busy    = (state != IDLE);
        if (state == IDLE) begin
            start = core.req;
        end
        if (state == DATA) begin
            done_ok = mem_rdy;
            expired = !mem_rdy && WAIT_EN && (wait_cnt == WAIT_LIMIT);
        end
    end

    // Memory-side registers, wait counter and completion pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ab        <= '0;
            rw        <= 1'b1;
            db_out    <= '0;
            db_oe     <= 1'b0;
            rdata_q   <= '0;
            wait_cnt  <= 8'd0;
            ack_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            ack_q     <= 1'b0;
            timeout_q <= 1'b0;
            if (start) begin
                ab <= core.addr_in;
                rw <= ~core.we;
                if (core.we) begin
                    db_out <= core.wdata;
                end
            end
            if (state == ADDR) begin
                wait_cnt <= 8'd0;
                db_oe    <= ~rw;
            end
            if (done_ok) begin
                if (rw) begin
                    rdata_q <= db_in;
                end
                ack_q <= 1'b1;
                db_oe <= 1'b0;
                rw    <= 1'b1;
            end else if (expired) begin
                ack_q     <= 1'b1;
                timeout_q <= 1'b1;
                db_oe     <= 1'b0;
                rw        <= 1'b1;
            end else if (state == DATA && wait_cnt != 8'hFF) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
        end
    end

    assign core.ack     = ack_q;
    assign core.timeout = timeout_q;
    assign core.rdata   = rdata_q;
    assign core.busy    = busy;

endmodule

// File: tb/tb_bus_interface_unit.sv
// tb/tb_bus_interface_unit.sv - directed scoreboard bench for bus_interface_unit
module tb_bus_interface_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [15:0] addr_in = '0;
    logic [7:0]  wdata = '0;
    logic [7:0]  db_in = '0;
    logic        mem_rdy = 1'b0;
    logic        sel = 1'b0;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [7:0] rdata;
        logic       to;
    } exp_t;
    exp_t sb[$];

    bus_interface_unit_if #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) ifa ();
    bus_interface_unit_if #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) ifb ();

    assign ifa.req = req;  assign ifa.we = we;  assign ifa.addr_in = addr_in;  assign ifa.wdata = wdata;
    assign ifb.req = req;  assign ifb.we = we;  assign ifb.addr_in = addr_in;  assign ifb.wdata = wdata;

    logic [15:0] ab_a, ab_b;
    logic        rw_a, rw_b, oe_a, oe_b;
    logic [7:0]  dout_a, dout_b;

    bus_interface_unit #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .MAX_WAIT(3)) dut_a (
        .clk(clk), .rst(rst), .core(ifa.slave), .ab(ab_a), .rw(rw_a),
        .db_out(dout_a), .db_oe(oe_a), .db_in(db_in), .mem_rdy(mem_rdy)
    );

    bus_interface_unit #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .MAX_WAIT(1)) dut_b (
        .clk(clk), .rst(rst), .core(ifb.slave), .ab(ab_b), .rw(rw_b),
        .db_out(dout_b), .db_oe(oe_b), .db_in(db_in), .mem_rdy(mem_rdy)
    );

    wire        ack_o   = sel ? ifb.ack     : ifa.ack;
    wire        to_o    = sel ? ifb.timeout : ifa.timeout;
    wire [7:0]  rdata_o = sel ? ifb.rdata   : ifa.rdata;
    wire        busy_o  = sel ? ifb.busy    : ifa.busy;
    wire [15:0] ab_o    = sel ? ab_b        : ab_a;
    wire        rw_o    = sel ? rw_b        : rw_a;
    wire [7:0]  dout_o  = sel ? dout_b      : dout_a;
    wire        oe_o    = sel ? oe_b        : oe_a;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Waits for ACK (bounded); mem_rdy is low for the first 'waits' DATA edges.
    task automatic wait_ack(input int waits, output int n, output int oe_cnt, output int busy_cnt);
        n = 0; oe_cnt = 0; busy_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            n++;
            if (ack_o) break;
            if (oe_o) oe_cnt++;
            if (busy_o) busy_cnt++;
            mem_rdy = (n >= waits + 1);
        end
        check("ack_seen", 32'(ack_o), 32'd1);
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        check({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, "_rdata"}, 32'(rdata_o), 32'(e.rdata));
            check({tag, "_timeout"}, 32'(to_o), 32'(e.to));
        end
    endtask

    initial begin
        int n, oe_cnt, busy_cnt;

        // reset state
        @(negedge clk);
        check("rst_ab", 32'(ab_o), 32'h0);
        check("rst_rw", 32'(rw_o), 32'd1);
        check("rst_dout", 32'(dout_o), 32'h0);
        check("rst_oe", 32'(oe_o), 32'd0);
        check("rst_rdata", 32'(rdata_o), 32'h0);
        check("rst_ack", 32'(ack_o), 32'd0);
        check("rst_to", 32'(to_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // zero-wait read
        req = 1'b1; we = 1'b0; addr_in = 16'h1234; db_in = 8'hA5; mem_rdy = 1'b1;
        sb.push_back('{rdata: 8'hA5, to: 1'b0});
        @(posedge clk); @(negedge clk);
        req = 1'b0;
        check("rd_ab", 32'(ab_o), 32'h1234);
        check("rd_rw", 32'(rw_o), 32'd1);
        check("rd_busy_e1", 32'(busy_o), 32'd1);
        wait_ack(0, n, oe_cnt, busy_cnt);
        check("rd_latency", 32'(n), 32'd2);
        check("rd_busy_cycles", 32'(busy_cnt + 1), 32'd2);
        check("rd_busy_at_ack", 32'(busy_o), 32'd0);
        pop_check("rd");
        @(negedge clk);
        check("rd_ack_drop", 32'(ack_o), 32'd0);

        // write with two wait states
        req = 1'b1; we = 1'b1; addr_in = 16'h0200; wdata = 8'h3C;
        sb.push_back('{rdata: 8'hA5, to: 1'b0});
        @(posedge clk); @(negedge clk);
        req = 1'b0; we = 1'b0; wdata = 8'hFF;
        check("wr_ab", 32'(ab_o), 32'h0200);
        check("wr_rw", 32'(rw_o), 32'd0);
        check("wr_dout", 32'(dout_o), 32'h3C);
        check("wr_oe_addr", 32'(oe_o), 32'd0);
        wait_ack(2, n, oe_cnt, busy_cnt);
        check("wr_latency", 32'(n), 32'd4);
        check("wr_oe_cycles", 32'(oe_cnt), 32'd3);
        check("wr_oe_exit", 32'(oe_o), 32'd0);
        check("wr_rw_exit", 32'(rw_o), 32'd1);
        check("wr_dout_held", 32'(dout_o), 32'h3C);
        pop_check("wr");
        @(negedge clk);

        // timeout (MAX_WAIT=3)
        req = 1'b1; we = 1'b0; addr_in = 16'h0300; db_in = 8'hEE;
        sb.push_back('{rdata: 8'hA5, to: 1'b1});
        @(posedge clk); @(negedge clk);
        req = 1'b0;
        wait_ack(100, n, oe_cnt, busy_cnt);
        check("to_latency", 32'(n), 32'd5);
        check("to_rw", 32'(rw_o), 32'd1);
        pop_check("to");
        @(negedge clk);
        check("to_ack_drop", 32'(ack_o), 32'd0);
        check("to_to_drop", 32'(to_o), 32'd0);

        // back-to-back reads with REQ held high
        mem_rdy = 1'b1; req = 1'b1; we = 1'b0; addr_in = 16'h0010; db_in = 8'h01;
        sb.push_back('{rdata: 8'h01, to: 1'b0});
        sb.push_back('{rdata: 8'h02, to: 1'b0});
        sb.push_back('{rdata: 8'h03, to: 1'b0});
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("b2b_ab_accept", 32'(ab_o), 32'h0010 + 32'(i));
            addr_in = 16'h0011 + 16'(i);
            if (i == 2) req = 1'b0;
            @(negedge clk);
            check("b2b_ab_hold", 32'(ab_o), 32'h0010 + 32'(i));
            check("b2b_no_ack", 32'(ack_o), 32'd0);
            @(negedge clk);
            check("b2b_ack", 32'(ack_o), 32'd1);
            pop_check("b2b");
            db_in = 8'h02 + 8'(i);
        end
        @(negedge clk);
        check("b2b_idle", 32'(busy_o), 32'd0);

        // reset during DATA of a write
        req = 1'b1; we = 1'b1; addr_in = 16'h0400; wdata = 8'h5A; mem_rdy = 1'b0;
        @(posedge clk); @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        check("rw_oe_before", 32'(oe_o), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rw_oe_async", 32'(oe_o), 32'd0);
        check("rw_rw_async", 32'(rw_o), 32'd1);
        check("rw_ab_async", 32'(ab_o), 32'h0);
        check("rw_rdata_async", 32'(rdata_o), 32'h0);
        check("rw_busy_async", 32'(busy_o), 32'd0);
        @(negedge clk);
        check("rw_no_ack1", 32'(ack_o), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rw_no_ack2", 32'(ack_o), 32'd0);
        req = 1'b1; we = 1'b0; addr_in = 16'h0500; db_in = 8'hC3;
        sb.push_back('{rdata: 8'hC3, to: 1'b0});
        @(posedge clk); @(negedge clk);
        req = 1'b0;
        wait_ack(0, n, oe_cnt, busy_cnt);
        check("rw_fresh_latency", 32'(n), 32'd2);
        pop_check("rw_fresh");
        @(negedge clk);

        // ready on the timeout edge wins (MAX_WAIT=1 instance)
        sel = 1'b1;
        req = 1'b1; we = 1'b0; addr_in = 16'h0600; db_in = 8'h77;
        sb.push_back('{rdata: 8'h77, to: 1'b0});
        @(posedge clk); @(negedge clk);
        req = 1'b0;
        wait_ack(1, n, oe_cnt, busy_cnt);
        check("sim_latency", 32'(n), 32'd3);
        pop_check("sim");
        @(negedge clk);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
